digit_divider_seq: RTL
======================

# digit_divider_seq

Sequential, parametrised binary-to-BCD converter for the time/clock counter displays. It accepts an unsigned binary value of up to `IN_W` bits on a start strobe, runs a shift-and-add-3 (double-dabble) conversion over `IN_W` clock cycles, and presents `DIGITS` packed BCD digits with a one-cycle done pulse. It sits between the counter cores (sec/msec, min/hour) and the FND scan/mux logic. It replaces per-field combinational `/` and `%` with one small shared iterative datapath, and it flags or saturates values that do not fit in the digit count.

## Interface
Parameters:
- `IN_W`, default 14: binary input width in bits, range 1..32.
- `DIGITS`, default 4: number of BCD output digits, range 1..8.

Ports:
- `clk`, input, 1 bit: single system clock; all state updates on its rising edge.
- `reset_n`, input, 1 bit: asynchronous, active-low reset.
- `i_start`, input, 1 bit: conversion request; sampled only while the block is idle.
- `i_value`, input, `IN_W` bits: unsigned binary value; captured on the accepting edge.
- `o_busy`, output, 1 bit: high while a conversion is running.
- `o_done`, output, 1 bit: one-cycle pulse when a new result is valid.
- `o_bcd`, output, `4*DIGITS` bits: packed BCD result; digit 0 (ones) is in [3:0], and the most significant digit is in the top nibble.
- `o_overflow`, output, 1 bit: high when the last result did not fit in `DIGITS` digits. Valid with `o_done` and held with `o_bcd`.

## Operation
- States: IDLE and CONV.
- IDLE: if `i_start`=1 on an edge, the block loads shift register ← `i_value`, scratch BCD ← 0, bit counter ← 0, and overflow flag ← 0, then goes to CONV.
- CONV, each edge, in this order:
  - Every scratch digit ≥5 gets +3.
  - {scratch, shift} shifts left by 1.
  - The bit shifted out of the top scratch digit is ORed into the sticky overflow flag.
  - Counter increments.
- CONV exit: on the edge where the counter reaches `IN_W`-1, the block:
  - registers `o_bcd`, using that edge's post-shift scratch value;
  - sets `o_overflow` ← sticky flag, including any carry produced on that edge;
  - sets `o_done` ← 1;
  - returns to IDLE.
- `o_busy` = (state == CONV), decoded combinationally from the state register.
- `i_start` while busy is ignored. There is no queueing and no error flag.
- `o_bcd` and `o_overflow` hold the last result until the next completion.
- Every digit of `o_bcd` is always in 0..9.
- Reset values: state IDLE; `o_busy` 0, `o_done` 0, `o_bcd` all zeros, `o_overflow` 0; internal registers 0.
- Reset asserted mid-conversion aborts it. No `o_done` is produced, and outputs return to reset values.

## Timing
- A start is accepted on edge k. CONV occupies edges k+1 … k+`IN_W`.
- `o_done`=1 and the new `o_bcd` are visible in the cycle after edge k+`IN_W`. Latency is `IN_W` cycles from the accepting edge.
- `o_busy` is high from after edge k until after edge k+`IN_W`, and is low during the `o_done` cycle.
- Back-to-back operation: a start asserted during the `o_done` cycle is accepted. Sustained throughput is one conversion per `IN_W`+1 cycles.
- `i_value` only needs to be stable at the accepting edge.

## Configuration
- `DIGIT_DIVIDER_SAT_EN` defined: when overflow is set, `o_bcd` is forced to all nines (for example 16'h9999 at the defaults).
- `DIGIT_DIVIDER_SAT_EN` not defined: `o_bcd` holds the low `DIGITS` digits, i.e. the value mod 10^`DIGITS`.
- In both cases `o_overflow` is reported identically.

## Test plan
- Defaults, `i_value`=0 with a 1-cycle start → `o_done` exactly 14 cycles after the accepting edge, `o_bcd`=16'h0000, `o_overflow`=0, `o_busy` high for 14 cycles.
- `i_value`=9999 → `o_bcd`=16'h9999, `o_overflow`=0. Then `i_value`=1234 started in the `o_done` cycle → `o_bcd`=16'h1234 after 14 more cycles.
- `i_value`=16383:
  - with `DIGIT_DIVIDER_SAT_EN` → `o_bcd`=16'h9999, `o_overflow`=1;
  - without the macro → `o_bcd`=16'h6383, `o_overflow`=1.
- `IN_W`=6, `DIGITS`=2 (seconds field): `i_value`=59 → `o_bcd`=8'h59, done 6 cycles after start, `o_overflow`=0.
- Start 1234, pulse `i_start` with `i_value`=42 at cycle 5 of CONV → single `o_done`, `o_bcd`=16'h1234, and 42 is never converted.
- Start 777, assert `reset_n`=0 mid-CONV for 2 cycles → no `o_done`, `o_bcd`=0, `o_busy`=0. A new start with 777 afterwards → 16'h0777.

Source files
------------

// File: rtl/digit_divider_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Define DIGIT_DIVIDER_SAT_EN to force all-nines on overflow; otherwise o_bcd is value mod 10^DIGITS.
module digit_divider_seq #(
   parameter int IN_W   = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_start,
   input  logic [IN_W-1:0]       i_value,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [4*DIGITS-1:0]   o_bcd,
   output logic                  o_overflow
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CAT_W = BCD_W + IN_W;
   localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_W - 1);
   localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};

   typedef enum logic {IDLE, CONV} state_t;

   state_t             state_q, state_d;
   logic [IN_W-1:0]    shift_q, shift_d;
   logic [BCD_W-1:0]   scratch_q, scratch_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic               overflow_q, overflow_d;
   logic               done_q, done_d;

   logic [BCD_W-1:0]   adj;
   logic [CAT_W-1:0]   cat_sh;
   logic [BCD_W-1:0]   scr_sh;
   logic [IN_W-1:0]    shf_sh;
   logic               carry;
   logic               ovf_next;
   logic [BCD_W-1:0]   result;

   // Per-digit add-3 correction; digits stay in 0..9 so the sum fits a nibble.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      assign adj[4*g +: 4] = (scratch_q[4*g +: 4] >= 4'd5) ? scratch_q[4*g +: 4] + 4'd3
                                                           : scratch_q[4*g +: 4];
   end

   // The bit leaving the top digit is lost; what remains is still correct mod 10^DIGITS.
   assign carry    = adj[BCD_W-1];
   assign cat_sh   = {adj[BCD_W-2:0], shift_q, 1'b0};
   assign scr_sh   = cat_sh[CAT_W-1:IN_W];
   assign shf_sh   = cat_sh[IN_W-1:0];
   assign ovf_next = ovf_q | carry;

`ifdef DIGIT_DIVIDER_SAT_EN
   assign result = ovf_next ? ALL_NINES : scr_sh;
`else
   assign result = scr_sh;
`endif

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      bcd_d      = bcd_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               shift_d   = i_value;
               scratch_d = '0;
               cnt_d     = '0;
               ovf_d     = 1'b0;
               state_d   = CONV;
            end
         end
         CONV: begin
            shift_d   = shf_sh;
            scratch_d = scr_sh;
            ovf_d     = ovf_next;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               cnt_d      = '0;
               bcd_d      = result;
               overflow_d = ovf_next;
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         scratch_q  <= scratch_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         bcd_q      <= bcd_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign o_busy     = (state_q == CONV);
   assign o_done     = done_q;
   assign o_bcd      = bcd_q;
   assign o_overflow = overflow_q;

endmodule
